multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the RV32I subset datapath: R-type, I-type ALU, LW, SW, BEQ.
- Decodes `instr` and steps each instruction through IF, ID, EX, MEM and WB.
- Drives the datapath control strobes PCSrc, ALUSrc, RegWrite, MemToReg, MemWrite, ALUCtrl and loadPC.
- PC advances only in WB, so `instr` from instruction memory is stable for the whole instruction.

Parameters:
- `ST_W`, 3, width of the `state` debug output.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  32  current instruction, stable from IF through WB.
- Zero  input  1  ALU zero flag from the datapath.
- PCSrc  output  1  1 = PC+branch_offset, 0 = PC+4.
- ALUSrc  output  1  1 = immediate as ALU operand 2.
- RegWrite  output  1  register file write enable.
- MemToReg  output  1  1 = write back memory read data.
- MemWrite  output  1  data memory write enable.
- ALUCtrl  output  4  ALU operation select.
- loadPC  output  1  PC update enable.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- halted  output  1  core stopped on an illegal instruction.
- state  output  ST_W  current FSM state, for debug.

Behaviour:
- Reset:
  - rst sampled high at a clk edge forces state=IF (0) and clears the decoded-op register.
  - All strobes are 0 in IF, so every output reads 0 during and after reset.
  - rst has priority over every transition, including mid-instruction and HALT.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; codes 6–7 go to IF.
- Transitions:
  - IF→ID→EX→MEM→WB→IF, unconditional, one cycle each. Every instruction takes exactly 5 cycles.
  - ID→HALT only with the optional feature enabled (see Optional Feature).
- Decode:
  - Registered at the clk edge leaving ID into an internal op class: RTYPE, ITYPE, LW, SW, BEQ, ILLEGAL.
  - ALUCtrl is also registered at that edge.
- Opcodes: 0110011 R-type, 0010011 I-type, 0000011 LW (funct3 010), 0100011 SW (funct3 010), 1100011 BEQ (funct3 000).
- R-type legal ops (funct7 0000000 unless noted): ADD, SUB (0100000), AND, OR, XOR, SLT, SLL, SRL, SRA (0100000).
- I-type legal ops: ADDI, ANDI, ORI, XORI, SLTI, SLLI/SRLI (funct7 0000000), SRAI (funct7 0100000).
- Anything else, including wrong funct3 for LW/SW/BEQ, decodes as ILLEGAL.
- ALUCtrl encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 XOR, 1101 SRL, 1110 SLL, 1111 SRA.
  - LW/SW use ADD; BEQ uses SUB.
  - ALUCtrl=0000 in IF/ID and after reset.
- Output rules (combinational from state and registered op; all 0 unless stated):
  - ALUSrc: 1 in EX, MEM and WB for ITYPE, LW, SW.
  - ALUCtrl: decoded value held in EX, MEM, WB.
  - MemWrite: 1 only in MEM for SW.
  - MemToReg: 1 in MEM and WB for LW.
  - RegWrite: 1 only in WB for RTYPE, ITYPE, LW.
  - loadPC: 1 in WB for every non-halted instruction, so PC updates on the clk edge leaving WB.
  - PCSrc: 1 only in WB when op=BEQ and Zero=1.
  - instr_done: 1 in WB only.
- ILLEGAL without the optional feature acts as a NOP: no RegWrite, no MemWrite, loadPC=1 with PCSrc=0.
- Zero is read only in WB. A Zero change in any other state has no effect.
- `instr` is sampled only in ID. Changes in other states do not alter the current instruction.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - ILLEGAL in ID goes to HALT instead of EX.
  - HALT holds until rst, with all strobes 0, loadPC=0 and instr_done=0.
  - halted=1 in HALT only.
- Undefined:
  - No HALT state is reachable; ILLEGAL retires as a NOP.
  - halted is tied to 0.

Test Plan:
- add x3,x1,x2 (0x002081B3) after reset:
  - state runs 0,1,2,3,4,0.
  - ALUCtrl=0010 and ALUSrc=0 in EX–WB.
  - RegWrite=1, loadPC=1, instr_done=1 only in cycle 5.
- lw x5,4(x1) (0x0040A283):
  - ALUSrc=1 and ALUCtrl=0010 in EX–WB; MemToReg=1 in MEM and WB.
  - RegWrite=1 in WB only; MemWrite=0 throughout.
- sw x5,8(x1) (0x0050A423):
  - MemWrite=1 in MEM only; RegWrite=0 throughout; ALUSrc=1; loadPC=1 in WB.
- beq x1,x2,8 (0x00208463):
  - With Zero=1 in WB: ALUCtrl=0110, PCSrc=1, loadPC=1.
  - Repeat with Zero=1 in EX then Zero=0 in WB: PCSrc=0.
- Assert rst for one cycle while in MEM of an SW:
  - Next cycle state=0 and MemWrite=0.
  - The following instruction completes normally in 5 cycles.
- instr=0xFFFFFFFF:
  - Macro undefined: 5-cycle NOP, RegWrite=0, MemWrite=0, loadPC=1 with PCSrc=0, halted=0.
  - Macro defined: state=5 after ID, halted=1 and all strobes 0 for 20 cycles, exits only on rst.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM for an RV32I subset datapath
// (R-type, I-type ALU, LW, SW, BEQ). Every instruction walks
// IF -> ID -> EX -> MEM -> WB and retires in exactly five cycles.
// The instruction is decoded once, on the edge leaving ID, into an op
// class and an ALU control code. All strobes are decoded combinationally
// from the current state and that registered op.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   - an ILLEGAL instruction in ID enters HALT. HALT holds until
//               rst and raises `halted`.
//   undefined - ILLEGAL retires as a NOP and `halted` is tied to 0.
module multicycle_ctrl #(
    parameter int ST_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            Zero,
    output logic            PCSrc,
    output logic            ALUSrc,
    output logic            RegWrite,
    output logic            MemToReg,
    output logic            MemWrite,
    output logic [3:0]      ALUCtrl,
    output logic            loadPC,
    output logic            instr_done,
    output logic            halted,
    output logic [ST_W-1:0] state
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_RTYPE   = 3'd0,
        OP_ITYPE   = 3'd1,
        OP_LW      = 3'd2,
        OP_SW      = 3'd3,
        OP_BEQ     = 3'd4,
        OP_ILLEGAL = 3'd5
    } op_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1100;
    localparam logic [3:0] ALU_SRL = 4'b1101;
    localparam logic [3:0] ALU_SLL = 4'b1110;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    state_t     state_q, state_d;
    op_t        op_q, op_dec;
    logic [3:0] alu_ctrl_q, alu_dec;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    // Register and immediate fields are the datapath's business, not ours.
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // Instruction decode into op class and ALU code; anything unrecognised is ILLEGAL.
    always_comb begin
        op_dec  = OP_ILLEGAL;
        alu_dec = ALU_AND;
        unique case (opcode)
            OPC_R: begin
                unique case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE) begin
                            op_dec = OP_RTYPE; alu_dec = ALU_ADD;
                        end else if (funct7 == F7_ALT) begin
                            op_dec = OP_RTYPE; alu_dec = ALU_SUB;
                        end
                    end
                    3'b111: if (funct7 == F7_BASE) begin op_dec = OP_RTYPE; alu_dec = ALU_AND; end
                    3'b110: if (funct7 == F7_BASE) begin op_dec = OP_RTYPE; alu_dec = ALU_OR;  end
                    3'b100: if (funct7 == F7_BASE) begin op_dec = OP_RTYPE; alu_dec = ALU_XOR; end
                    3'b010: if (funct7 == F7_BASE) begin op_dec = OP_RTYPE; alu_dec = ALU_SLT; end
                    3'b001: if (funct7 == F7_BASE) begin op_dec = OP_RTYPE; alu_dec = ALU_SLL; end
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            op_dec = OP_RTYPE; alu_dec = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            op_dec = OP_RTYPE; alu_dec = ALU_SRA;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_I: begin
                unique case (funct3)
                    3'b000: begin op_dec = OP_ITYPE; alu_dec = ALU_ADD; end
                    3'b111: begin op_dec = OP_ITYPE; alu_dec = ALU_AND; end
                    3'b110: begin op_dec = OP_ITYPE; alu_dec = ALU_OR;  end
                    3'b100: begin op_dec = OP_ITYPE; alu_dec = ALU_XOR; end
                    3'b010: begin op_dec = OP_ITYPE; alu_dec = ALU_SLT; end
                    3'b001: if (funct7 == F7_BASE) begin op_dec = OP_ITYPE; alu_dec = ALU_SLL; end
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            op_dec = OP_ITYPE; alu_dec = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            op_dec = OP_ITYPE; alu_dec = ALU_SRA;
                        end
                    end
                    default: ;
                endcase
            end
            OPC_LW:  if (funct3 == 3'b010) begin op_dec = OP_LW;  alu_dec = ALU_ADD; end
            OPC_SW:  if (funct3 == 3'b010) begin op_dec = OP_SW;  alu_dec = ALU_ADD; end
            OPC_BEQ: if (funct3 == 3'b000) begin op_dec = OP_BEQ; alu_dec = ALU_SUB; end
            default: ;
        endcase
    end

    // State, op class and ALU code registers; decode is captured only when leaving ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IF;
            op_q       <= OP_ILLEGAL;
            alu_ctrl_q <= ALU_AND;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                op_q       <= op_dec;
                alu_ctrl_q <= alu_dec;
            end
        end
    end

    // Next-state logic: fixed five-step walk, optional trap into HALT.
    always_comb begin
        state_d = S_IF;
        unique case (state_q)
            S_IF:  state_d = S_ID;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ID:  state_d = (op_dec == OP_ILLEGAL) ? S_HALT : S_EX;
`else
            S_ID:  state_d = S_EX;
`endif
            S_EX:  state_d = S_MEM;
            S_MEM: state_d = S_WB;
            S_WB:  state_d = S_IF;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`else
            S_HALT: state_d = S_IF;
`endif
            default: state_d = S_IF;
        endcase
    end

    // Datapath strobes from state and registered op; IF, ID and HALT drive nothing.
    always_comb begin
        PCSrc      = 1'b0;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = 1'b0;
        MemWrite   = 1'b0;
        ALUCtrl    = ALU_AND;
        loadPC     = 1'b0;
        instr_done = 1'b0;
        unique case (state_q)
            S_EX: begin
                ALUSrc  = (op_q == OP_ITYPE) || (op_q == OP_LW) || (op_q == OP_SW);
                ALUCtrl = alu_ctrl_q;
            end
            S_MEM: begin
                ALUSrc   = (op_q == OP_ITYPE) || (op_q == OP_LW) || (op_q == OP_SW);
                ALUCtrl  = alu_ctrl_q;
                MemWrite = (op_q == OP_SW);
                MemToReg = (op_q == OP_LW);
            end
            S_WB: begin
                ALUSrc     = (op_q == OP_ITYPE) || (op_q == OP_LW) || (op_q == OP_SW);
                ALUCtrl    = alu_ctrl_q;
                MemToReg   = (op_q == OP_LW);
                RegWrite   = (op_q == OP_RTYPE) || (op_q == OP_ITYPE) || (op_q == OP_LW);
                loadPC     = 1'b1;
                PCSrc      = (op_q == OP_BEQ) && Zero;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

    assign state = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Per-cycle expectations are derived from
// the instruction class and pushed to a scoreboard queue. Each entry is
// popped and compared against the DUT outputs on the falling clock edge.
module tb_multicycle_ctrl;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL = 5;

    typedef struct {
        logic [2:0]  st;
        logic [11:0] outs;   // {PCSrc,ALUSrc,RegWrite,MemToReg,MemWrite,ALUCtrl,loadPC,instr_done,halted}
        logic [11:0] mask;
        logic        zero;   // Zero value to apply during this cycle
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, MemWrite, loadPC, instr_done, halted;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    multicycle_ctrl #(.ST_W(3)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .MemWrite(MemWrite), .ALUCtrl(ALUCtrl), .loadPC(loadPC),
        .instr_done(instr_done), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    // Build the expected entry for cycle c (0=IF .. 4=WB) of an instruction of class k.
    function automatic exp_t model(input int k, input logic [3:0] alu, input int c,
                                   input logic z, input string tag);
        exp_t e;
        logic imm;
        imm = (k == K_I) || (k == K_LW) || (k == K_SW);
        e.st   = 3'(c);
        e.outs = {(c == 4) && (k == K_BEQ) && z,
                  (c >= 2) && imm,
                  (c == 4) && ((k == K_R) || (k == K_I) || (k == K_LW)),
                  (c >= 3) && (k == K_LW),
                  (c == 3) && (k == K_SW),
                  (c >= 2) ? alu : 4'b0000,
                  (c == 4),
                  (c == 4),
                  1'b0};
        // ALU code for an illegal instruction is not defined, so it is not checked.
        e.mask = (k == K_ILL && c >= 2) ? 12'b1111_1000_0111 : 12'hFFF;
        e.zero = z;
        e.tag  = tag;
        return e;
    endfunction

    function automatic exp_t idle_entry(input logic [2:0] st, input logic hl, input string tag);
        exp_t e;
        e.st = st; e.outs = {11'b0, hl}; e.mask = 12'hFFF; e.zero = 1'b0; e.tag = tag;
        return e;
    endfunction

    // Pop one entry, apply its Zero, and compare at the falling edge. Leaves time at posedge+1.
    task automatic check_cycle(input logic assert_rst);
        exp_t e;
        logic [11:0] act;
        e = sb.pop_front();
        Zero = e.zero;
        @(negedge clk);
        act = {PCSrc, ALUSrc, RegWrite, MemToReg, MemWrite, ALUCtrl, loadPC, instr_done, halted};
        n_cmp++;
        if (state !== e.st) begin
            n_bad++;
            $display("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
        end
        n_cmp++;
        if ((act & e.mask) !== (e.outs & e.mask)) begin
            n_bad++;
            $display("FAIL %s outputs: got %b expected %b (mask %b)", e.tag, act, e.outs, e.mask);
        end
        $display("  %s: state=%0d outs=%b", e.tag, state, act);
        if (assert_rst) rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction and check its first ncyc cycles; zv[c] is Zero in cycle c.
    task automatic run_instr(input string name, input logic [31:0] ins, input int k,
                             input logic [3:0] alu, input logic [4:0] zv, input int ncyc);
        instr = ins;
        for (int c = 0; c < ncyc; c++)
            sb.push_back(model(k, alu, c, zv[c], $sformatf("%s c%0d", name, c)));
        for (int c = 0; c < ncyc; c++)
            check_cycle(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 32'h002081B3; Zero = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(idle_entry(3'd0, 1'b0, "reset"));
        check_cycle(1'b0);  // rst still high across this edge, state stays IF
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        run_instr("add", 32'h002081B3, K_R, 4'b0010, 5'b00000, 5);
        run_instr("sub", 32'h40208233, K_R, 4'b0110, 5'b11111, 5);
    endtask

    task automatic test_itype();
        run_instr("srai", 32'h4030D293, K_I, 4'b1111, 5'b00000, 5);
        run_instr("xori", 32'h0050C313, K_I, 4'b1100, 5'b00000, 5);
    endtask

    task automatic test_load_store();
        run_instr("lw", 32'h0040A283, K_LW, 4'b0010, 5'b00000, 5);
        run_instr("sw", 32'h0050A423, K_SW, 4'b0010, 5'b00000, 5);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", 32'h00208463, K_BEQ, 4'b0110, 5'b10000, 5);
        run_instr("beq_not",   32'h00208463, K_BEQ, 4'b0110, 5'b00100, 5);
    endtask

    task automatic test_instr_change();
        // instr swaps to SW after ID; the ADD must still retire unchanged.
        instr = 32'h002081B3;
        for (int c = 0; c < 5; c++)
            sb.push_back(model(K_R, 4'b0010, c, 1'b0, $sformatf("add_swap c%0d", c)));
        check_cycle(1'b0);
        check_cycle(1'b0);
        instr = 32'h0050A423;
        for (int c = 2; c < 5; c++) check_cycle(1'b0);
    endtask

    task automatic test_reset_mid();
        run_instr("sw_abort", 32'h0050A423, K_SW, 4'b0010, 5'b00000, 3);
        sb.push_back(model(K_SW, 4'b0010, 3, 1'b0, "sw_abort c3"));
        check_cycle(1'b1);  // raise rst during MEM
        rst = 1'b0;
        sb.push_back(idle_entry(3'd0, 1'b0, "after_rst"));
        // After the idle check we are in IF again, so the next instruction starts cleanly.
        instr = 32'h002081B3;
        Zero = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (state !== 3'd0 || MemWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL after_rst: state=%0d MemWrite=%b expected state=0 MemWrite=0", state, MemWrite);
        end
        void'(sb.pop_front());
        // The next rising edge moves IF->ID; re-sync to IF by checking the add from ID onward.
        @(posedge clk); #1;
        for (int c = 1; c < 5; c++)
            sb.push_back(model(K_R, 4'b0010, c, 1'b0, $sformatf("add_post c%0d", c)));
        for (int c = 1; c < 5; c++) check_cycle(1'b0);
    endtask

    task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
        run_instr("ill", 32'hFFFFFFFF, K_ILL, 4'b0000, 5'b00000, 2);
        for (int i = 0; i < 20; i++)
            sb.push_back(idle_entry(3'd5, 1'b1, $sformatf("halt %0d", i)));
        for (int i = 0; i < 20; i++) check_cycle(i == 19);
        rst = 1'b0;
        sb.push_back(idle_entry(3'd0, 1'b0, "halt_rst"));
        rst = 1'b1;
        check_cycle(1'b0);
        rst = 1'b0;
        run_instr("add_after_halt", 32'h002081B3, K_R, 4'b0010, 5'b00000, 5);
`else
        run_instr("ill", 32'hFFFFFFFF, K_ILL, 4'b0000, 5'b11111, 5);
        run_instr("lw_bad_f3", 32'h0040B283, K_ILL, 4'b0000, 5'b00000, 5);
`endif
    endtask

    initial begin
        rst = 1'b1; instr = '0; Zero = 1'b0;
        test_reset();
        test_rtype();
        test_itype();
        test_load_store();
        test_branch();
        test_instr_change();
        test_reset_mid();
        test_illegal();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
